// File: rtl/distance_qualifier.sv
// Distance zone qualifier: arming, hysteresis classification, N-sample confirmation, alarm silencing.
// Optional DIST_AVG_EN macro selects a 4-sample moving-average filter instead of pass-through.
module distance_qualifier #(
  parameter int unsigned WARN_CM     = 50,
  parameter int unsigned ALARM_CM    = 20,
  parameter int unsigned HYST_CM     = 4,
  parameter int unsigned CONFIRM_N   = 3,
  parameter int unsigned ARM_SAMPLES = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Dist_Valid,
  input  logic [7:0] Distance,
  input  logic       Ack,
  output logic [7:0] Filtered_Dist,
  output logic [1:0] Zone,
  output logic       Zone_Change,
  output logic       Alarm_Active
);

  typedef enum logic [2:0] {ST_ARMING, ST_SAFE, ST_WARN, ST_ALARM, ST_SILENCED} state_t;

  localparam logic [1:0] Z_SAFE   = 2'b00;
  localparam logic [1:0] Z_WARN   = 2'b01;
  localparam logic [1:0] Z_ALARM  = 2'b10;
  localparam logic [1:0] Z_ARMING = 2'b11;

  localparam logic [8:0] ALARM_TH = 9'(ALARM_CM);
  localparam logic [8:0] WARN_TH  = 9'(WARN_CM);
  localparam logic [8:0] ALARM_HY = 9'(ALARM_CM + HYST_CM);
  localparam logic [8:0] WARN_HY  = 9'(WARN_CM + HYST_CM);
  localparam logic [3:0] CONF     = 4'(CONFIRM_N);
  localparam logic [7:0] ARM_LAST = 8'(ARM_SAMPLES - 1);

  state_t      r_state, w_next;
  logic [7:0]  r_filt, w_filt_next;
  logic [3:0]  r_cnt, w_cnt_inc;
  logic [1:0]  r_cand, w_target, w_raw, w_cur_zone;
  logic [7:0]  r_arm_cnt;
  logic        r_zchg;
  logic        w_acc, w_confirm;
  logic [8:0]  w_d;

  function automatic logic [1:0] zone_of(input state_t s);
    case (s)
      ST_SAFE:              return Z_SAFE;
      ST_WARN:              return Z_WARN;
      ST_ALARM, ST_SILENCED: return Z_ALARM;
      default:              return Z_ARMING;
    endcase
  endfunction

  function automatic state_t state_of(input logic [1:0] z);
    case (z)
      Z_WARN:  return ST_WARN;
      Z_ALARM: return ST_ALARM;
      default: return ST_SAFE;
    endcase
  endfunction

  assign w_acc = Dist_Valid && (Distance != 8'd0);

`ifdef DIST_AVG_EN
  logic [7:0] r_hist [3];
  logic [9:0] w_sum;
  assign w_sum       = 10'(Distance) + 10'(r_hist[0]) + 10'(r_hist[1]) + 10'(r_hist[2]);
  assign w_filt_next = w_sum[9:2];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_hist[0] <= '0;
      r_hist[1] <= '0;
      r_hist[2] <= '0;
    end else if (w_acc) begin
      r_hist[0] <= Distance;
      r_hist[1] <= r_hist[0];
      r_hist[2] <= r_hist[1];
    end
  end
`else
  assign w_filt_next = Distance;
`endif

  // Classification uses the filtered value including the sample arriving this cycle.
  always_comb begin
    w_d        = {1'b0, w_filt_next};
    w_cur_zone = zone_of(r_state);
    if (w_d <= ALARM_TH)     w_raw = Z_ALARM;
    else if (w_d <= WARN_TH) w_raw = Z_WARN;
    else                     w_raw = Z_SAFE;
    case (r_state)
      ST_WARN: begin
        if (w_raw == Z_ALARM)   w_target = Z_ALARM;
        else if (w_d > WARN_HY) w_target = Z_SAFE;
        else                    w_target = Z_WARN;
      end
      ST_ALARM, ST_SILENCED: w_target = (w_d > ALARM_HY) ? w_raw : Z_ALARM;
      default:               w_target = w_raw;
    endcase
    w_cnt_inc = (w_target == r_cand) ? r_cnt + 4'd1 : 4'd1;
    w_confirm = (w_target != w_cur_zone) && (w_cnt_inc >= CONF);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= ST_ARMING;
      r_filt    <= '0;
      r_cnt     <= '0;
      r_cand    <= '0;
      r_arm_cnt <= '0;
      r_zchg    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_zchg  <= (zone_of(w_next) != zone_of(r_state));
      if (w_acc) begin
        r_filt <= w_filt_next;
        if (r_state == ST_ARMING) begin
          r_arm_cnt <= r_arm_cnt + 8'd1;
        end else if ((w_target == w_cur_zone) || w_confirm) begin
          r_cnt <= '0;
        end else begin
          r_cnt  <= w_cnt_inc;
          r_cand <= w_target;
        end
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_ARMING: if (w_acc && (r_arm_cnt == ARM_LAST)) w_next = ST_SAFE;
      ST_ALARM: begin
        if (Ack)                     w_next = ST_SILENCED;
        else if (w_acc && w_confirm) w_next = state_of(w_target);
      end
      default: if (w_acc && w_confirm) w_next = state_of(w_target);
    endcase
  end

  always_comb begin
    Zone          = zone_of(r_state);
    Alarm_Active  = (r_state == ST_ALARM);
    Zone_Change   = r_zchg;
    Filtered_Dist = r_filt;
  end

endmodule

// File: tb/tb_distance_qualifier.sv
// Table-driven scoreboard bench for distance_qualifier with default parameters.
module tb_distance_qualifier;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       Dist_Valid = 1'b0;
  logic [7:0] Distance = '0;
  logic       Ack = 1'b0;
  logic [7:0] Filtered_Dist;
  logic [1:0] Zone;
  logic       Zone_Change;
  logic       Alarm_Active;

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       a;
    logic [7:0] f;
    logic [1:0] z;
    logic       c;
    logic       al;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  distance_qualifier #(.WARN_CM(50), .ALARM_CM(20), .HYST_CM(4), .CONFIRM_N(3), .ARM_SAMPLES(8)) dut (
    .CLK(CLK), .RST(RST), .Dist_Valid(Dist_Valid), .Distance(Distance), .Ack(Ack),
    .Filtered_Dist(Filtered_Dist), .Zone(Zone), .Zone_Change(Zone_Change), .Alarm_Active(Alarm_Active)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: act=%0d exp=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic v, input int d, input logic a, input int f, input int z,
                     input logic c, input logic al);
    vec_t t;
    t.v = v; t.d = 8'(d); t.a = a; t.f = 8'(f); t.z = 2'(z); t.c = c; t.al = al;
    tbl.push_back(t);
  endtask

  task automatic apply(input vec_t t);
    vec_t e;
    @(negedge CLK);
    Dist_Valid = t.v;
    Distance   = t.d;
    Ack        = t.a;
    exp_q.push_back(t);
    @(posedge CLK);
    #1;
    Dist_Valid = 1'b0;
    Distance   = '0;
    Ack        = 1'b0;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk("filtered", int'(Filtered_Dist), int'(e.f));
      chk("zone", int'(Zone), int'(e.z));
      chk("zone_change", int'(Zone_Change), int'(e.c));
      chk("alarm", int'(Alarm_Active), int'(e.al));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_zone"}, int'(Zone), 3);
    chk({tag, "_filtered"}, int'(Filtered_Dist), 0);
    chk({tag, "_zone_change"}, int'(Zone_Change), 0);
    chk({tag, "_alarm"}, int'(Alarm_Active), 0);
  endtask

  function automatic int avg_fill(input int k, input int val);
`ifdef DIST_AVG_EN
    return (val * ((k < 4) ? k : 4)) / 4;
`else
    return val + 0 * k;
`endif
  endfunction

  initial begin
    #23;
    check_reset_outputs("reset");
    @(negedge CLK);
    RST = 1'b1;

    for (int k = 1; k <= 7; k++) add(1, 100, 0, avg_fill(k, 100), 3, 0, 0);
    add(1, 100, 0, 100, 0, 1, 0);
    add(0, 0, 0, 100, 0, 0, 0);
`ifdef DIST_AVG_EN
    add(1, 20, 0, 80, 0, 0, 0);
    add(1, 20, 0, 60, 0, 0, 0);
    add(1, 20, 0, 40, 0, 0, 0);
    add(1, 20, 0, 20, 0, 0, 0);
`else
    add(1, 15, 0, 15, 0, 0, 0); add(1, 15, 0, 15, 0, 0, 0); add(1, 100, 0, 100, 0, 0, 0);
    add(1, 15, 0, 15, 0, 0, 0); add(1, 15, 0, 15, 0, 0, 0); add(1, 15, 0, 15, 2, 1, 1);
    add(0, 0, 0, 15, 2, 0, 1);
    for (int k = 0; k < 3; k++) add(1, 22, 0, 22, 2, 0, 1);
    add(1, 25, 0, 25, 2, 0, 1); add(1, 25, 0, 25, 2, 0, 1); add(1, 25, 0, 25, 1, 1, 0);
    add(1, 15, 0, 15, 1, 0, 0); add(1, 15, 0, 15, 1, 0, 0); add(1, 15, 0, 15, 2, 1, 1);
    add(1, 0, 0, 15, 2, 0, 1);
    add(1, 60, 1, 60, 2, 0, 0);
    add(1, 60, 0, 60, 2, 0, 0); add(1, 60, 0, 60, 0, 1, 0);
    add(0, 0, 1, 60, 0, 0, 0);
    add(1, 100, 0, 100, 0, 0, 0); add(0, 0, 0, 100, 0, 0, 0); add(1, 0, 0, 100, 0, 0, 0);
    add(0, 0, 0, 100, 0, 0, 0); add(1, 0, 0, 100, 0, 0, 0); add(1, 40, 0, 40, 0, 0, 0);
    add(0, 0, 0, 40, 0, 0, 0); add(1, 40, 0, 40, 0, 0, 0); add(1, 40, 0, 40, 1, 1, 0);
    for (int k = 0; k < 3; k++) add(1, 54, 0, 54, 1, 0, 0);
    add(1, 55, 0, 55, 1, 0, 0); add(1, 55, 0, 55, 1, 0, 0); add(1, 55, 0, 55, 0, 1, 0);
    add(1, 51, 0, 51, 0, 0, 0);
    add(1, 50, 0, 50, 0, 0, 0); add(1, 50, 0, 50, 0, 0, 0); add(1, 50, 0, 50, 1, 1, 0);
    add(1, 21, 0, 21, 1, 0, 0);
    add(1, 20, 0, 20, 1, 0, 0); add(1, 20, 0, 20, 1, 0, 0); add(1, 20, 0, 20, 2, 1, 1);
    for (int k = 0; k < 3; k++) add(1, 24, 0, 24, 2, 0, 1);
    add(0, 0, 1, 24, 2, 0, 0);
    for (int k = 0; k < 3; k++) add(1, 10, 0, 10, 2, 0, 0);
    add(1, 200, 0, 200, 2, 0, 0); add(1, 200, 0, 200, 2, 0, 0); add(1, 200, 0, 200, 0, 1, 0);
    add(1, 15, 0, 15, 0, 0, 0); add(1, 15, 0, 15, 0, 0, 0); add(1, 15, 0, 15, 2, 1, 1);
`endif

    foreach (tbl[i]) apply(tbl[i]);

    // Mid-operation asynchronous reset, sampled without a clock edge.
    @(posedge CLK);
    #3;
    RST = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;

    begin
      vec_t t;
      for (int k = 1; k <= 8; k++) begin
        t.v = 1'b0; t.d = '0; t.a = 1'b0; t.f = 8'(avg_fill(k - 1, 30));
        t.z = 2'd3; t.c = 1'b0; t.al = 1'b0;
        if (k == 1) t.f = 8'd0;
        apply(t);
        t.v = 1'b1; t.d = 8'd30; t.f = 8'(avg_fill(k, 30));
        t.z = (k == 8) ? 2'd0 : 2'd3;
        t.c = (k == 8);
        apply(t);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/distance_qualifier.md
DISTANCE_QUALIFIER -- requirements
Module: distance_qualifier

Interface
REQ-001 The block SHALL have these parameters:
- WARN_CM, 50, warn threshold in cm.
- ALARM_CM, 20, alarm threshold in cm; must be less than WARN_CM.
- HYST_CM, 4, hysteresis margin in cm.
- CONFIRM_N, 3, consecutive agreeing samples required to change zone (range 1..15).
- ARM_SAMPLES, 8, valid samples ignored after reset (range 1..255).

REQ-002 The block SHALL have these ports, with one clock and an asynchronous active-low reset:
- CLK, in, 1, trigger-domain clock.
- RST, in, 1, asynchronous active-low reset.
- Dist_Valid, in, 1, one-cycle strobe marking a new Distance.
- Distance, in, 8, raw distance in cm from the sensor controller; 0 means no echo.
- Ack, in, 1, operator silence request, level-sampled.
- Filtered_Dist, out, 8, distance used for classification.
- Zone, out, 2, encoding 00=SAFE, 01=WARN, 10=ALARM, 11=ARMING.
- Zone_Change, out, 1, one-cycle pulse when Zone changes.
- Alarm_Active, out, 1, drives alarm sound enable.

Function
REQ-003 A sample SHALL be accepted only when Dist_Valid=1 and Distance is nonzero; samples with Distance=0 SHALL NOT change the filter, counters or state.
REQ-004 The state machine SHALL have exactly these states: ARMING, SAFE, WARN, ALARM, SILENCED.
REQ-005 In ARMING, the block SHALL count accepted samples and move to SAFE on the cycle after the ARM_SAMPLES-th accepted sample, with no classification while arming.
REQ-006 The target zone for filtered distance d SHALL be:
- ALARM if d <= ALARM_CM.
- Otherwise WARN if d <= WARN_CM.
- Otherwise SAFE.
REQ-007 Hysteresis SHALL apply as follows:
- Leaving ALARM/SILENCED for a farther zone requires d > ALARM_CM+HYST_CM.
- Leaving WARN for SAFE requires d > WARN_CM+HYST_CM.
- Otherwise the target equals the current zone.
REQ-008 The candidate counter (4 bits) SHALL behave as follows on each accepted sample:
- Cleared if target equals the current zone.
- Incremented if target equals the stored candidate.
- Otherwise reloaded to 1 with the new candidate.
- When it reaches CONFIRM_N, the state becomes the candidate and the counter clears.
REQ-009 State, Zone, Filtered_Dist and Zone_Change SHALL update on the clock edge following the Dist_Valid cycle, which is a latency of 1.
REQ-010 Zone SHALL be 10 in both ALARM and SILENCED; Alarm_Active SHALL be 1 only in ALARM.
REQ-011 Ack=1 while in ALARM SHALL move the block to SILENCED on the next edge; Ack in any other state SHALL be ignored.
REQ-012 SILENCED SHALL leave only to WARN or SAFE via REQ-007/REQ-008; a target of ALARM while SILENCED SHALL keep the block SILENCED.
REQ-013 If Ack and an accepted sample arrive in the same cycle while in ALARM:
- SILENCED takes priority over any sample-driven transition.
- The sample still updates the filter and candidate counter.
REQ-014 Zone_Change SHALL pulse for one cycle coincident with every Zone value change, including ARMING->SAFE, and SHALL NOT pulse for ALARM->SILENCED.
REQ-015 Threshold comparisons SHALL be unsigned 9-bit so that threshold+HYST_CM above 255 does not wrap.

Reset
REQ-016 Asserting RST low SHALL asynchronously force the following outputs and internal values:
- State ARMING, Zone=11.
- Filtered_Dist=0, Zone_Change=0, Alarm_Active=0.
- Counters and filter history cleared.
REQ-017 Reset mid-operation, including in ALARM, SHALL restart the full ARM_SAMPLES arming period after release.

Configuration
REQ-018 With DIST_AVG_EN defined, Filtered_Dist SHALL be the 4-sample moving average of accepted samples:
- 10-bit sum, shifted right by 2, truncated.
- History cleared on reset and filled during ARMING.
REQ-019 Without DIST_AVG_EN, Filtered_Dist SHALL equal the last accepted Distance and no history registers SHALL exist.

Verification
REQ-020 Default parameters: reset, then 8 samples of 100 -> Zone=11 until the edge after the 8th sample, then Zone=00 with one Zone_Change pulse.
REQ-021 Armed, no DIST_AVG_EN: samples 15,15,15 -> Zone=10 and Alarm_Active=1 one cycle after the 3rd sample; 15,15,100 -> no change.
REQ-022 In ALARM: samples of 22 -> stays ALARM (hysteresis); three samples of 25 -> WARN.
REQ-023 In ALARM: Ack=1 together with a sample of 60 -> SILENCED, Alarm_Active=0, Zone=10, no Zone_Change; two more samples of 60 -> SAFE.
REQ-024 Armed SAFE: samples 100,0,0,40 interleaved with Dist_Valid=0 cycles -> zeros ignored and counter at 1; RST low mid-sequence -> outputs at reset values immediately.
REQ-025 With DIST_AVG_EN, armed with a 100-filled window: samples 20,20,20,20 -> Filtered_Dist 80,60,40,20.
